// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the two-requester ROM arbiter.
package rom_arbiter_pkg;

  // Transaction FSM: accept a request, read the ROM, hold the response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester ids; also the encoding of the last-grant register.
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  // Full-width range check so huge addresses never alias into the ROM.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes
// to the requester that was not granted last.
module rr_arbiter2
  import rom_arbiter_pkg::*;
(
  input  logic       valid_if,
  input  logic       valid_dm,
  input  logic       last_grant,
  output logic [1:0] grant       // bit 0 = fetch, bit 1 = data-load
);

  // Pick one requester, alternating on ties.
  always_comb begin
    grant = 2'b00;
    if (valid_if && valid_dm) begin
      grant = (last_grant == REQ_IF) ? 2'b10 : 2'b01;
    end else if (valid_if) begin
      grant = 2'b01;
    end else if (valid_dm) begin
      grant = 2'b10;
    end else begin
      grant = 2'b00;
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates fetch and data-load reads onto one combinational ROM port
// and returns a registered word (or an out-of-range error) to the winner.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  input  logic              dm_valid,
  input  logic [31:0]       dm_addr,
  output logic              dm_ready,
  output logic              dm_resp_valid,
  input  logic              dm_resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic [31:0]       rom_address,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  state_t      state;
  state_t      state_next;
  logic        last_grant;   // owner of the transaction in READ/RESP
  logic [31:0] addr_q;
  logic [1:0]  grant;
  logic        accept;

  rr_arbiter2 u_rr (
    .valid_if   (if_valid),
    .valid_dm   (dm_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs; everything is held low while in reset.
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    if_ready      = 1'b0;
    dm_ready      = 1'b0;
    if_resp_valid = 1'b0;
    dm_resp_valid = 1'b0;
    rom_address   = 32'd0;
    if (reset) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            accept     = 1'b1;
            if_ready   = grant[0];
            dm_ready   = grant[1];
            state_next = READ;
          end else begin
            state_next = IDLE;
          end
        end
        READ: begin
          rom_address = addr_q;
          state_next  = RESP;
        end
        RESP: begin
          if (last_grant == REQ_IF) begin
            if_resp_valid = 1'b1;
            state_next    = if_resp_ready ? IDLE : RESP;
          end else begin
            dm_resp_valid = 1'b1;
            state_next    = dm_resp_ready ? IDLE : RESP;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Latch the winner's address at accept; capture ROM word or error in READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_DM;
      addr_q     <= 32'd0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant[1] ? REQ_DM : REQ_IF;
        addr_q     <= grant[1] ? dm_addr : if_addr;
      end
      if (state == READ) begin
        if (addr_in_range(addr_q, DEPTH)) begin
          resp_data <= rom_data;
          resp_err  <= 1'b0;
        end else begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end
      end
    end
  end

endmodule
